// File: rtl/fft_pkg.sv
// Shared types and constants for the 16-point pipelined FFT.
package fft_pkg;

  localparam int DW = 16;
  localparam int FRAC = 8;
  localparam int N = 16;

  typedef logic signed [DW-1:0] sample_t;
  typedef logic signed [2*DW-1:0] prod_t;

  typedef struct packed {
    sample_t re;
    sample_t im;
  } cplx_t;

  // W16^i = cos(2*pi*i/16) - j*sin(2*pi*i/16), Q8.8
  function automatic cplx_t twiddle(input logic [2:0] i);
    cplx_t w;
    unique case (i)
      3'd0: w = '{re: 16'sd256, im: 16'sd0};
      3'd1: w = '{re: 16'sd237, im: -16'sd98};
      3'd2: w = '{re: 16'sd181, im: -16'sd181};
      3'd3: w = '{re: 16'sd98, im: -16'sd237};
      3'd4: w = '{re: 16'sd0, im: -16'sd256};
      3'd5: w = '{re: -16'sd98, im: -16'sd237};
      3'd6: w = '{re: -16'sd181, im: -16'sd181};
      3'd7: w = '{re: -16'sd237, im: -16'sd98};
    endcase
    return w;
  endfunction

  function automatic int bitrev4(input int i);
    return ((i & 1) << 3) | ((i & 2) << 1)
         | ((i & 4) >> 1) | ((i & 8) >> 3);
  endfunction

endpackage

// File: rtl/fft_butterfly.sv
// Radix-2 DIT butterfly: p = a + w*b, q = a - w*b.
module fft_butterfly
  import fft_pkg::*;
(
  input  cplx_t a,
  input  cplx_t b,
  input  cplx_t w,
  output cplx_t p,
  output cplx_t q
);

  sample_t br, bi, wr, wi;
  sample_t tr, ti;
  prod_t   pr, pi;

  assign br = b.re;
  assign bi = b.im;
  assign wr = w.re;
  assign wi = w.im;

  assign pr = prod_t'(br) * prod_t'(wr)
            - prod_t'(bi) * prod_t'(wi);
  assign pi = prod_t'(br) * prod_t'(wi)
            + prod_t'(bi) * prod_t'(wr);

  // floor shift, then keep the low word
  assign tr = sample_t'(pr >>> FRAC);
  assign ti = sample_t'(pi >>> FRAC);

  assign p.re = a.re + tr;
  assign p.im = a.im + ti;
  assign q.re = a.re - tr;
  assign q.im = a.im - ti;

endmodule

// File: rtl/fft.sv
// Fully parallel 16-point radix-2 DIT FFT, four registered stages.
module fft
  import fft_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic signed [DW-1:0] X0_Real, X1_Real, X2_Real, X3_Real,
  input  logic signed [DW-1:0] X4_Real, X5_Real, X6_Real, X7_Real,
  input  logic signed [DW-1:0] X8_Real, X9_Real, X10_Real, X11_Real,
  input  logic signed [DW-1:0] X12_Real, X13_Real, X14_Real, X15_Real,
  input  logic signed [DW-1:0] X0_Im, X1_Im, X2_Im, X3_Im,
  input  logic signed [DW-1:0] X4_Im, X5_Im, X6_Im, X7_Im,
  input  logic signed [DW-1:0] X8_Im, X9_Im, X10_Im, X11_Im,
  input  logic signed [DW-1:0] X12_Im, X13_Im, X14_Im, X15_Im,
  output logic signed [DW-1:0] O_X0_Real, O_X1_Real, O_X2_Real, O_X3_Real,
  output logic signed [DW-1:0] O_X4_Real, O_X5_Real, O_X6_Real, O_X7_Real,
  output logic signed [DW-1:0] O_X8_Real, O_X9_Real, O_X10_Real, O_X11_Real,
  output logic signed [DW-1:0] O_X12_Real, O_X13_Real, O_X14_Real, O_X15_Real,
  output logic signed [DW-1:0] O_X0_Im, O_X1_Im, O_X2_Im, O_X3_Im,
  output logic signed [DW-1:0] O_X4_Im, O_X5_Im, O_X6_Im, O_X7_Im,
  output logic signed [DW-1:0] O_X8_Im, O_X9_Im, O_X10_Im, O_X11_Im,
  output logic signed [DW-1:0] O_X12_Im, O_X13_Im, O_X14_Im, O_X15_Im
);

  logic [N-1:0][DW-1:0] xr, xi, yr, yi;

  assign xr = {X15_Real, X14_Real, X13_Real, X12_Real,
               X11_Real, X10_Real, X9_Real, X8_Real,
               X7_Real, X6_Real, X5_Real, X4_Real,
               X3_Real, X2_Real, X1_Real, X0_Real};
  assign xi = {X15_Im, X14_Im, X13_Im, X12_Im,
               X11_Im, X10_Im, X9_Im, X8_Im,
               X7_Im, X6_Im, X5_Im, X4_Im,
               X3_Im, X2_Im, X1_Im, X0_Im};

  assign {O_X15_Real, O_X14_Real, O_X13_Real, O_X12_Real,
          O_X11_Real, O_X10_Real, O_X9_Real, O_X8_Real,
          O_X7_Real, O_X6_Real, O_X5_Real, O_X4_Real,
          O_X3_Real, O_X2_Real, O_X1_Real, O_X0_Real} = yr;
  assign {O_X15_Im, O_X14_Im, O_X13_Im, O_X12_Im,
          O_X11_Im, O_X10_Im, O_X9_Im, O_X8_Im,
          O_X7_Im, O_X6_Im, O_X5_Im, O_X4_Im,
          O_X3_Im, O_X2_Im, O_X1_Im, O_X0_Im} = yi;

  cplx_t x  [N];
  cplx_t nx [4][N];
  cplx_t q  [4][N];

  genvar i, s, j;

  for (i = 0; i < N; i++) begin : g_io
    localparam int R = bitrev4(i);
    assign x[i].re = xr[R];
    assign x[i].im = xi[R];
    assign yr[i] = q[3][i].re;
    assign yi[i] = q[3][i].im;
  end

  for (s = 0; s < 4; s++) begin : g_stg
    for (j = 0; j < N / 2; j++) begin : g_bf
      localparam int H = 1 << s;
      localparam int IA = (j / H) * 2 * H + (j % H);
      localparam int IB = IA + H;
      localparam int TI = (j % H) * (8 >> s);
      cplx_t a, b;
      if (s == 0) begin : g_in
        assign a = x[IA];
        assign b = x[IB];
      end else begin : g_pipe
        assign a = q[s-1][IA];
        assign b = q[s-1][IB];
      end
      fft_butterfly u_bf (
        .a (a),
        .b (b),
        .w (twiddle(3'(TI))),
        .p (nx[s][IA]),
        .q (nx[s][IB])
      );
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int t = 0; t < 4; t++)
        for (int k = 0; k < N; k++)
          q[t][k] <= '0;
    end else begin
      q <= nx;
    end
  end

endmodule

// File: tb/tb_fft.sv
// Self-checking bench for fft: scoreboard of expected spectra per frame.
module tb_fft;

  localparam int LAT = 4;
  localparam int K_ZERO = 0;
  localparam int K_IMP = 1;
  localparam int K_DC = 2;
  localparam int K_ALT = 3;
  localparam int K_COS = 4;

  logic clk = 1'b0;
  logic rst;
  logic signed [15:0] xr [16];
  logic signed [15:0] xi [16];
  logic signed [15:0] yr [16];
  logic signed [15:0] yi [16];

  int q_re [$];
  int q_im [$];
  int q_tol [$];
  int n_cmp = 0;
  int n_bad = 0;
  int cosv [16] = '{256, 237, 181, 98, 0, -98, -181, -237,
                    -256, -237, -181, -98, 0, 98, 181, 237};

  always #5 clk = ~clk;

  fft dut (
    .clk(clk), .rst(rst),
    .X0_Real(xr[0]), .X1_Real(xr[1]), .X2_Real(xr[2]), .X3_Real(xr[3]),
    .X4_Real(xr[4]), .X5_Real(xr[5]), .X6_Real(xr[6]), .X7_Real(xr[7]),
    .X8_Real(xr[8]), .X9_Real(xr[9]), .X10_Real(xr[10]), .X11_Real(xr[11]),
    .X12_Real(xr[12]), .X13_Real(xr[13]), .X14_Real(xr[14]), .X15_Real(xr[15]),
    .X0_Im(xi[0]), .X1_Im(xi[1]), .X2_Im(xi[2]), .X3_Im(xi[3]),
    .X4_Im(xi[4]), .X5_Im(xi[5]), .X6_Im(xi[6]), .X7_Im(xi[7]),
    .X8_Im(xi[8]), .X9_Im(xi[9]), .X10_Im(xi[10]), .X11_Im(xi[11]),
    .X12_Im(xi[12]), .X13_Im(xi[13]), .X14_Im(xi[14]), .X15_Im(xi[15]),
    .O_X0_Real(yr[0]), .O_X1_Real(yr[1]), .O_X2_Real(yr[2]), .O_X3_Real(yr[3]),
    .O_X4_Real(yr[4]), .O_X5_Real(yr[5]), .O_X6_Real(yr[6]), .O_X7_Real(yr[7]),
    .O_X8_Real(yr[8]), .O_X9_Real(yr[9]), .O_X10_Real(yr[10]),
    .O_X11_Real(yr[11]), .O_X12_Real(yr[12]), .O_X13_Real(yr[13]),
    .O_X14_Real(yr[14]), .O_X15_Real(yr[15]),
    .O_X0_Im(yi[0]), .O_X1_Im(yi[1]), .O_X2_Im(yi[2]), .O_X3_Im(yi[3]),
    .O_X4_Im(yi[4]), .O_X5_Im(yi[5]), .O_X6_Im(yi[6]), .O_X7_Im(yi[7]),
    .O_X8_Im(yi[8]), .O_X9_Im(yi[9]), .O_X10_Im(yi[10]), .O_X11_Im(yi[11]),
    .O_X12_Im(yi[12]), .O_X13_Im(yi[13]), .O_X14_Im(yi[14]), .O_X15_Im(yi[15])
  );

  // Drive one frame; optionally push its expected spectrum.
  task automatic load(input int kind, input bit push);
    int e;
    for (int n = 0; n < 16; n++) begin
      xr[n] = '0;
      xi[n] = '0;
      case (kind)
        K_IMP: if (n == 0) xr[n] = 16'sd256;
        K_DC:  xr[n] = 16'sd256;
        K_ALT: xr[n] = (n % 2 == 0) ? 16'sd256 : -16'sd256;
        K_COS: xr[n] = 16'(cosv[n]);
        default: ;
      endcase
    end
    if (push) begin
      q_tol.push_back(kind == K_COS ? 4 : 0);
      for (int k = 0; k < 16; k++) begin
        e = 0;
        case (kind)
          K_IMP: e = 256;
          K_DC:  e = (k == 0) ? 4096 : 0;
          K_ALT: e = (k == 8) ? 4096 : 0;
          K_COS: e = (k == 1 || k == 15) ? 2048 : 0;
          default: e = 0;
        endcase
        q_re.push_back(e);
        q_im.push_back(0);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    load(K_DC, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < 16; k++) begin
      n_cmp++;
      if (yr[k] !== 16'sd0 || yi[k] !== 16'sd0) begin
        n_bad++;
        $display("FAIL reset bin %0d: got re=%0d im=%0d, want 0", k, yr[k], yi[k]);
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_frames();
    int kinds [4] = '{K_IMP, K_DC, K_ALT, K_COS};
    int tol, er, ei, dr, di;
    for (int f = 0; f < 4; f++) begin
      load(kinds[f], 1'b1);
      @(posedge clk);
      #1;
      load(K_ZERO, 1'b0);
      repeat (LAT - 1) @(posedge clk);
      #1;
      if (q_tol.size() == 0 || q_re.size() < 16) begin
        n_cmp++;
        n_bad++;
        $display("FAIL frames: scoreboard empty");
      end else begin
        tol = q_tol.pop_front();
        for (int k = 0; k < 16; k++) begin
          er = q_re.pop_front();
          ei = q_im.pop_front();
          dr = int'(yr[k]) - er;
          di = int'(yi[k]) - ei;
          n_cmp++;
          if ($isunknown(yr[k]) || $isunknown(yi[k]) ||
              dr > tol || dr < -tol || di > tol || di < -tol) begin
            n_bad++;
            $display("FAIL frame%0d bin %0d: got re=%0d im=%0d, want re=%0d im=%0d tol %0d",
                     f, k, yr[k], yi[k], er, ei, tol);
          end
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    int kinds [3] = '{K_IMP, K_DC, K_ALT};
    int tol, er, ei, dr, di;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int c = 0; c < 3 + LAT - 1; c++) begin
      if (c < 3) load(kinds[c], 1'b1);
      else load(K_ZERO, 1'b0);
      @(posedge clk);
      #1;
      if (c < LAT - 1) begin
        for (int k = 0; k < 16; k++) begin
          n_cmp++;
          if (yr[k] !== 16'sd0 || yi[k] !== 16'sd0) begin
            n_bad++;
            $display("FAIL b2b early cyc%0d bin %0d: got re=%0d im=%0d, want 0",
                     c + 1, k, yr[k], yi[k]);
          end
        end
      end else if (q_tol.size() == 0 || q_re.size() < 16) begin
        n_cmp++;
        n_bad++;
        $display("FAIL b2b: scoreboard empty");
      end else begin
        tol = q_tol.pop_front();
        for (int k = 0; k < 16; k++) begin
          er = q_re.pop_front();
          ei = q_im.pop_front();
          dr = int'(yr[k]) - er;
          di = int'(yi[k]) - ei;
          n_cmp++;
          if ($isunknown(yr[k]) || $isunknown(yi[k]) ||
              dr > tol || dr < -tol || di > tol || di < -tol) begin
            n_bad++;
            $display("FAIL b2b cyc%0d bin %0d: got re=%0d im=%0d, want re=%0d im=%0d",
                     c + 1, k, yr[k], yi[k], er, ei);
          end
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    int tol, er, ei, dr, di;
    load(K_DC, 1'b1);
    @(posedge clk);
    #1;
    load(K_ALT, 1'b1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    load(K_IMP, 1'b0);
    @(posedge clk);
    #1;
    q_re.delete();
    q_im.delete();
    q_tol.delete();
    for (int k = 0; k < 16; k++) begin
      n_cmp++;
      if (yr[k] !== 16'sd0 || yi[k] !== 16'sd0) begin
        n_bad++;
        $display("FAIL midrst flush bin %0d: got re=%0d im=%0d, want 0", k, yr[k], yi[k]);
      end
    end
    rst = 1'b0;
    load(K_IMP, 1'b1);
    for (int c = 0; c < LAT; c++) begin
      @(posedge clk);
      #1;
      load(K_ZERO, 1'b0);
      if (c < LAT - 1) begin
        for (int k = 0; k < 16; k++) begin
          n_cmp++;
          if (yr[k] !== 16'sd0 || yi[k] !== 16'sd0) begin
            n_bad++;
            $display("FAIL midrst hold cyc%0d bin %0d: got re=%0d im=%0d, want 0",
                     c + 1, k, yr[k], yi[k]);
          end
        end
      end else if (q_tol.size() == 0 || q_re.size() < 16) begin
        n_cmp++;
        n_bad++;
        $display("FAIL midrst: scoreboard empty");
      end else begin
        tol = q_tol.pop_front();
        for (int k = 0; k < 16; k++) begin
          er = q_re.pop_front();
          ei = q_im.pop_front();
          dr = int'(yr[k]) - er;
          di = int'(yi[k]) - ei;
          n_cmp++;
          if ($isunknown(yr[k]) || $isunknown(yi[k]) ||
              dr > tol || dr < -tol || di > tol || di < -tol) begin
            n_bad++;
            $display("FAIL midrst result bin %0d: got re=%0d im=%0d, want re=%0d im=%0d",
                     k, yr[k], yi[k], er, ei);
          end
        end
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    load(K_ZERO, 1'b0);
    test_reset();
    test_frames();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fft.md
Name: fft

Overview:
- Fully parallel, pipelined 16-point radix-2 decimation-in-time complex FFT.
- Data is signed Q8.8 fixed point (8 integer bits, 8 fraction bits; 256 = 1.0).
- Accepts one 16-sample complex frame per clock and produces the 16 complex frequency bins 4 clocks later.
- Sits between a sample-capture front end and spectral post-processing.

Parameters:
- DW, 16, sample/result word width (signed two's complement).
- FRAC, 8, fraction bits of data and twiddles.

Ports:
- clk  in  1  single clock; all registers update on the rising edge.
- rst  in  1  synchronous, active-high reset.
- X0_Real..X15_Real  in  16 each  real part of time sample n (n=0..15), Q8.8 signed.
- X0_Im..X15_Im  in  16 each  imaginary part of sample n, Q8.8 signed.
- O_X0_Real..O_X15_Real  out  16 each  real part of bin k (natural order), Q8.8 signed.
- O_X0_Im..O_X15_Im  out  16 each  imaginary part of bin k, Q8.8 signed.

Behaviour:
- Computes X[k] = sum over n of x[n]·W16^(nk), with W16 = e^(-j2π/16).
- No normalisation or scaling is applied.
- Inputs are consumed in natural order. Bit-reversal is pure wiring into stage 1.
- Four butterfly stages (span 1, 2, 4, 8), each with a registered output.
  - Latency is exactly 4 rising edges from input to output.
  - Throughput is one full frame per cycle; there is no handshake and no valid signal.
  - A new frame may be applied on every cycle.
- Butterfly: A' = A + W·B, B' = A − W·B.
  - Stage s uses W16^(k·16/2^s) for butterfly index k.
- Twiddles: Q8.8 constants, cos/sin rounded to nearest: 1.0=256, cos22.5°=237, cos45°=181, cos67.5°=98.
  - Stored as an internal constant LUT indexed 0..7.
- Complex multiply:
  - Each 16x16 product is formed at 32 bits signed.
  - Real = (ar·wr − ai·wi) >>> 8 and imag = (ar·wi + ai·wr) >>> 8, using an arithmetic shift (truncation toward −inf).
  - The result is then truncated to 16 bits.
  - Multiplying by W^0 must be bit-exact (pass-through allowed).
- Additions/subtractions are 16-bit two's complement with wrap-around on overflow, no saturation.
- Reset: while rst=1 at a rising edge, all pipeline registers clear to 0. All outputs read 0 from the next edge.
  - After rst deasserts, the first valid result appears 4 edges after the first input frame captured post-reset.
  - Reset asserted mid-stream discards all in-flight frames.
- Outputs change only on clock edges. There is no combinational input-to-output path.

Decomposition:
- Shared package fft_pkg holds:
  - the sample typedef (signed [15:0]);
  - the complex struct {re, im};
  - FRAC;
  - the 8-entry twiddle constant table (re, im).
- One natural sub-module, fft_butterfly: complex multiply by twiddle plus add/sub, combinational.
  - Instantiated 8 per stage via generate.
  - The stage registers live in fft itself.

Test Plan:
- Impulse: X0_Real=256, all others 0 -> after 4 cycles every O_Xk_Real=256, O_Xk_Im=0 (exact).
- DC: all X_Real=256 -> O_X0_Real=4096, every other output 0 (exact).
- Alternating: X_Real = +256, −256, +256, ... -> O_X8_Real=4096, all others 0 (exact).
- Cosine bin 1: X_n_Real = round(256·cos(2πn/16)) -> O_X1_Real ≈ 2048 and O_X15_Real ≈ 2048 within ±4 LSB; all other outputs within ±4 LSB of 0.
- Streaming and latency: apply impulse, DC, alternating frames on consecutive cycles -> the three expected result sets appear on consecutive cycles starting at cycle 4. Outputs are 0 before cycle 4 when started from reset.
- Reset mid-stream: pulse rst for 1 cycle during streaming -> all outputs 0 at the next edge, and remain 0 until 4 edges after the first post-reset frame. That frame's result is then correct.
